idx_vec_build: RTL and testbench



---
 rtl/idx_vec_build_if.sv | 26 ++
 rtl/idx_vec_build.sv | 121 ++++++++++++
 tb/tb_idx_vec_build.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/idx_vec_build_if.sv
// rtl/idx_vec_build_if.sv - index stream in / accumulated vector out handshake bundle for idx_vec_build
interface idx_vec_build_if #(
    parameter int WIDTH = 7,
    parameter int IW    = $clog2(WIDTH)
) ();
    logic             i_valid;
    logic             o_ready;
    logic [IW-1:0]    i_index;
    logic             i_thermo;
    logic             i_last;
    logic             i_clear;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_vector;
    logic             o_err;

    modport slave (
        input  i_valid, i_index, i_thermo, i_last, i_clear, i_ready,
        output o_ready, o_valid, o_vector, o_err
    );

    modport master (
        output i_valid, i_index, i_thermo, i_last, i_clear, i_ready,
        input  o_ready, o_valid, o_vector, o_err
    );
endinterface

// File: rtl/idx_vec_build.sv
// rtl/idx_vec_build.sv - decode index stream (one-hot/thermometer) and OR-accumulate into a vector; IDX_VEC_BUILD_RANGECHECK_EN adds o_err range flag
module idx_vec_build #(
    parameter int WIDTH = 7
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cg,
    idx_vec_build_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW:0] WIDTH_W = (IW+1)'(WIDTH);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] vec_q;
    logic             valid_q;

    logic             acc_xfer;
    logic             out_xfer;
    logic             in_range;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] acc_d;

    assign bus.o_ready  = (state_q == ACCUM);
    assign bus.o_valid  = valid_q;
    assign bus.o_vector = vec_q;

    assign acc_xfer = bus.i_valid & bus.o_ready & i_cg;
    assign out_xfer = valid_q & bus.i_ready & i_cg;

    // Indices past the top bit (non power-of-two WIDTH) decode to nothing.
    always_comb begin
        in_range = ({1'b0, bus.i_index} < WIDTH_W);
        dec      = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (bus.i_thermo) begin
                dec[b] = in_range & (IW'(b) <= bus.i_index);
            end else begin
                dec[b] = in_range & (IW'(b) == bus.i_index);
            end
        end
        base  = bus.i_clear ? '0 : acc_q;
        acc_d = base | dec;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
        end else if (i_cg) begin
            case (state_q)
                ACCUM: begin
                    if (acc_xfer) begin
                        if (bus.i_last) begin
                            vec_q   <= acc_d;
                            valid_q <= 1'b1;
                            acc_q   <= '0;
                            state_q <= HOLD;
                        end else begin
                            acc_q   <= acc_d;
                        end
                    end else if (bus.i_clear) begin
                        acc_q <= '0;
                    end
                end
                HOLD: begin
                    if (out_xfer) begin
                        valid_q <= 1'b0;
                        vec_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

`ifdef IDX_VEC_BUILD_RANGECHECK_EN
    logic flag_q;
    logic err_q;
    logic flag_d;

    // The sticky flag follows the same clear/restart rules as the accumulator.
    assign flag_d    = (bus.i_clear ? 1'b0 : flag_q) | ~in_range;
    assign bus.o_err = err_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            flag_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (i_cg) begin
            if (acc_xfer) begin
                assert (in_range) else $warning("idx_vec_build: out-of-range index %0d accepted", bus.i_index);
                if (bus.i_last) begin
                    err_q  <= flag_d;
                    flag_q <= 1'b0;
                end else begin
                    flag_q <= flag_d;
                end
            end else if (state_q == ACCUM && bus.i_clear) begin
                flag_q <= 1'b0;
            end
            if (out_xfer) begin
                err_q  <= 1'b0;
                flag_q <= 1'b0;
            end
        end
    end
`else
    assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_idx_vec_build.sv
// tb/tb_idx_vec_build.sv - directed plus randomized self-checking bench for idx_vec_build against a set-union reference model
module tb_idx_vec_build;
    localparam int W = 7;
`ifdef IDX_VEC_BUILD_RANGECHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic cg;
    int   errors = 0;
    int   checks = 0;

    logic [W-1:0] m_acc;
    bit           m_flag;
    logic [W-1:0] exp_vec;
    bit           exp_err;

    idx_vec_build_if #(.WIDTH(W)) bus ();

    idx_vec_build #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_cg    (cg),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: the set of bit positions named by an index.
    function automatic logic [W-1:0] ref_dec(int idx, bit th);
        logic [W-1:0] r;
        r = '0;
        if (idx < W) begin
            for (int p = 0; p < W; p++) begin
                if ((th && p <= idx) || (!th && p == idx)) r[p] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input bit th, input bit last, input bit clr);
        logic [W-1:0] v;
        bit           f;
        bus.i_valid  = 1'b1;
        bus.i_index  = 3'(idx);
        bus.i_thermo = th;
        bus.i_last   = last;
        bus.i_clear  = clr;
        chk("ready_before_send", bus.o_ready, 1);
        v = (clr ? '0 : m_acc) | ref_dec(idx, th);
        f = (clr ? 1'b0 : m_flag) | (idx >= W);
        if (last) begin
            exp_vec = v;
            exp_err = RC & f;
            m_acc   = '0;
            m_flag  = 1'b0;
        end else begin
            m_acc  = v;
            m_flag = f;
        end
        step();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_clear = 1'b0;
        if (last) begin
            chk("valid_after_last", bus.o_valid, 1);
            chk("vector_after_last", bus.o_vector, exp_vec);
            chk("err_after_last", bus.o_err, exp_err);
            chk("ready_in_hold", bus.o_ready, 0);
        end
    endtask

    task automatic drain(input int hold);
        for (int k = 0; k < hold; k++) begin
            step();
            chk("hold_valid", bus.o_valid, 1);
            chk("hold_vector", bus.o_vector, exp_vec);
            chk("hold_ready", bus.o_ready, 0);
        end
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        chk("drain_valid", bus.o_valid, 0);
        chk("drain_vector", bus.o_vector, 0);
        chk("drain_err", bus.o_err, 0);
        chk("drain_ready", bus.o_ready, 1);
    endtask

    initial begin
        int len;
        int idx;
        bit th;
        bit clr;

        m_acc        = '0;
        m_flag       = 1'b0;
        exp_vec      = '0;
        exp_err      = 1'b0;
        cg           = 1'b1;
        rst_n        = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_index  = 3'd5;
        bus.i_thermo = 1'b0;
        bus.i_last   = 1'b1;
        bus.i_clear  = 1'b0;
        bus.i_ready  = 1'b0;

        step();
        step();
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_vector", bus.o_vector, 0);
        chk("rst_err", bus.o_err, 0);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        rst_n       = 1'b1;
        step();
        chk("rst_ready", bus.o_ready, 1);
        chk("rst_valid_after", bus.o_valid, 0);

        send(1, 0, 0, 0);
        send(4, 0, 0, 0);
        send(6, 0, 1, 0);
        chk("tp_onehot", bus.o_vector, 7'b1010010);
        drain(3);

        send(3, 1, 1, 0);
        chk("tp_thermo", bus.o_vector, 7'b0001111);
        drain(0);

        send(2, 1, 0, 0);
        send(5, 0, 1, 0);
        chk("tp_mixed", bus.o_vector, 7'b0100111);
        drain(1);

        send(0, 0, 0, 0);
        send(2, 0, 0, 0);
        send(4, 0, 1, 1);
        chk("tp_clear_same_cycle", bus.o_vector, 7'b0010000);
        drain(0);

        send(3, 0, 0, 0);
        bus.i_clear = 1'b1;
        step();
        bus.i_clear = 1'b0;
        m_acc  = '0;
        m_flag = 1'b0;
        send(1, 0, 1, 0);
        chk("tp_clear_standalone", bus.o_vector, 7'b0000010);
        drain(0);

        send(7, 0, 0, 0);
        send(0, 0, 1, 0);
        chk("tp_oor_vector", bus.o_vector, 7'b0000001);
        chk("tp_oor_err", bus.o_err, 32'(RC));
        drain(0);
        send(2, 0, 1, 0);
        chk("tp_oor_err_cleared", bus.o_err, 0);
        drain(0);

        send(7, 1, 1, 0);
        chk("tp_zero_vector_last", bus.o_vector, 0);
        drain(0);

        // Gated clock in ACCUM: an offered last index must not complete.
        cg           = 1'b0;
        bus.i_valid  = 1'b1;
        bus.i_index  = 3'd5;
        bus.i_last   = 1'b1;
        step();
        chk("cg_accum_valid", bus.o_valid, 0);
        chk("cg_accum_ready", bus.o_ready, 1);
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        cg          = 1'b1;
        step();
        chk("cg_accum_nothing", bus.o_valid, 0);

        send(6, 1, 1, 0);
        chk("tp_all_ones", bus.o_vector, 7'b1111111);
        cg          = 1'b0;
        bus.i_ready = 1'b1;
        step();
        step();
        chk("cg_hold_valid", bus.o_valid, 1);
        chk("cg_hold_vector", bus.o_vector, exp_vec);
        cg = 1'b1;
        step();
        bus.i_ready = 1'b0;
        chk("cg_release_valid", bus.o_valid, 0);

        send(2, 0, 1, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_hold_valid", bus.o_valid, 0);
        chk("rst_hold_vector", bus.o_vector, 0);
        send(5, 0, 1, 0);
        chk("rst_hold_fresh", bus.o_vector, 7'b0100000);
        drain(0);

        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                idx = $urandom_range(0, 7);
                th  = 1'($urandom);
                clr = (k > 0) && ($urandom_range(0, 4) == 0);
                if ($urandom_range(0, 3) == 0) step();
                send(idx, th, (k == len - 1), clr);
            end
            drain($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
